// File: rtl/seq_detect_ctrl_if.sv
// Control/data bundle for seq_detect_ctrl: run control, pattern load, serial input and status.
interface seq_detect_ctrl_if #(
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int FILL_W = 3
);
  logic              start;
  logic              stop;
  logic [PAT_W-1:0]  pattern;
  logic [CNT_W-1:0]  match_limit;
  logic              x;
  logic              x_valid;
  logic              y;
  logic [FILL_W-1:0] outstate;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, pattern, match_limit, x, x_valid,
    input  y, outstate, match_cnt, busy, done
  );

  modport slave (
    input  start, stop, pattern, match_limit, x, x_valid,
    output y, outstate, match_cnt, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller around a programmable serial pattern detector with a match limit.
// Build option OVERLAP_EN: matches may share bits; otherwise the fill restarts after each match.
module seq_detect_ctrl #(
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int FILL_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  seq_detect_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | sampling serial bits
  // DONE  | match limit reached, held until start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [1:0]        state_q, state_d;
  logic [PAT_W-1:0]  window_q, window_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  lim_q, lim_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              y_q, y_d;

  logic [FILL_W-1:0] fill_base, fill_inc;
  logic [PAT_W-1:0]  win_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;

  // Without overlap the fill shows PAT_W alongside y, then restarts on the next edge.
`ifdef OVERLAP_EN
  assign fill_base = fill_q;
`else
  assign fill_base = y_q ? '0 : fill_q;
`endif

  assign win_shift = {window_q[PAT_W-2:0], bus.x};
  assign fill_inc  = (fill_base == FILL_FULL) ? fill_base : fill_base + 1'b1;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign hit       = (fill_inc == FILL_FULL) && (win_shift == pat_q);

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_base;
    pat_d    = pat_q;
    lim_d    = lim_q;
    cnt_d    = cnt_q;
    y_d      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          window_d = '0;
          fill_d   = '0;
          cnt_d    = '0;
          pat_d    = bus.pattern;
          lim_d    = bus.match_limit;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.x_valid) begin
          window_d = win_shift;
          fill_d   = fill_inc;
          if (hit) begin
            y_d   = 1'b1;
            cnt_d = cnt_inc;
            if ((lim_q != '0) && (cnt_inc == lim_q)) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      window_q <= '0;
      fill_q   <= '0;
      pat_q    <= '0;
      lim_q    <= '0;
      cnt_q    <= '0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      lim_q    <= lim_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.outstate  = fill_q;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller around a programmable serial pattern detector. It gates a qualified serial bit stream into the detector window and counts matches. It stops automatically once a match limit is reached, and reports progress and status to the surrounding control logic. It supersedes hard-coded single-pattern detector FSMs wherever a pattern has to be loaded and a run has to be started, stopped or bounded.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, match counter and limit width
- FILL_W, 3, outstate width; must satisfy 2^FILL_W > PAT_W

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; latches pattern and match_limit
- stop  in  1  abort a run
- pattern  in  PAT_W  target sequence; MSB is the first bit received
- match_limit  in  CNT_W  matches before auto-stop; 0 means unlimited
- x  in  1  serial data bit
- x_valid  in  1  x is sampled only when high
- y  out  1  one-cycle match pulse
- outstate  out  FILL_W  valid bits currently in window, saturating at PAT_W
- match_cnt  out  CNT_W  matches in current/last run
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- FSM states:
  - IDLE=0: waiting for start.
  - RUN=1: sampling.
  - DONE=2: limit reached.
  - Encoding 3 is unreachable and recovers to IDLE.
- Reset: state IDLE.
  - y, outstate, match_cnt, busy, done all 0.
  - Window and latched pattern/limit cleared.
- IDLE/DONE with start=1:
  - Go to RUN.
  - Window, fill and match_cnt clear to 0.
  - pattern and match_limit are latched.
- RUN:
  - On each edge with x_valid=1, window shifts left and takes in x at the LSB.
  - fill increments, saturating at PAT_W.
- Match condition: fill (after the update) = PAT_W and window (after the update) = latched pattern.
- On match:
  - y=1 for one cycle.
  - match_cnt increments, saturating at all-ones.
  - Fill handling depends on the configuration (see below).
- Limit:
  - If match_limit≠0 and the match brings match_cnt to match_limit, go to DONE on the same edge.
  - Further x is ignored.
- stop=1 in RUN: go to IDLE. match_cnt is retained and window/fill are frozen.
- start in RUN: ignored.
- start and stop in the same cycle:
  - In RUN, stop wins.
  - In IDLE/DONE, start wins.
- DONE is held until start or rst. match_cnt is retained.
- busy = (state==RUN).
- done = (state==DONE).
- outstate = fill.

## Timing
- All outputs are registered.
- y, match_cnt and outstate update on the edge that samples the completing bit. They are visible for the following cycle.
- Latency from the last pattern bit sampled to y high is 1 edge.
- done/busy change on the same edge as y for an auto-stop.
- Consecutive bits may arrive every cycle. x_valid=0 cycles insert gaps without disturbing the window.
- A match on the final limited bit still pulses y.
- rst asserted mid-run forces the reset values immediately, without waiting for clk.

## Configuration
- OVERLAP_EN defined:
  - fill is not cleared on a match.
  - Trailing bits of a match may begin the next match, so a match is possible on every valid bit once the window is full.
- OVERLAP_EN undefined (default):
  - On a match, fill clears to 0. The window contents are don't-care.
  - The next match needs PAT_W fresh valid bits.
  - outstate reads 0 in the cycle after a match.

## Test plan
- Reset: assert rst asynchronously mid-RUN -> y=0, busy=0, done=0, match_cnt=0, outstate=0 before the next clk edge.
- Non-overlap, pattern=4'b1011, limit=0, stream 1,0,1,1,0,1,1,0,1,1,0 every cycle -> y pulses after bits 4 and 10; match_cnt=2. OVERLAP_EN build -> y after bits 4, 7, 10; match_cnt=3.
- Limit: pattern=1011, limit=1, same stream -> y and done after bit 4; busy=0 thereafter; match_cnt stays 1; start then re-arms with match_cnt=0.
- Gaps: stream 1,0,1,1 with x_valid low for 3 cycles between each bit -> single y after the 4th valid bit; outstate steps 1,2,3,then 4 in the same cycle as y (non-overlap build: 0 in the next cycle).
- Stop/start collision: start=stop=1 in RUN -> IDLE with match_cnt retained. start=stop=1 in IDLE -> RUN.
- Saturation: CNT_W=2, pattern=4'b0000, OVERLAP_EN build, 10 zeros, limit=0 -> match_cnt saturates at 3; y continues pulsing after bits 4 to 10.
